id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline, with integrated load-use hazard detection and bubble/flush insertion.
- Captures decoded ID-stage operands and control each cycle.
- Presents the registered fields, including ID_EX_rd_reg1/ID_EX_rd_reg2, to the EX stage and the forwarding unit.
- Drives the stall to the PC and the IF/ID register.

Parameters:
XLEN, 32, datapath width (PC, register data, immediate)
ALUOP_W, 4, width of the ALU operation code

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_data  in  XLEN  register-file read data 1
id_rs2_data  in  XLEN  register-file read data 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_rd  in  5  destination register index
id_uses_rs1  in  1  instruction actually reads rs1
id_uses_rs2  in  1  instruction actually reads rs2
id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch  in  1 each  decoded control
id_aluop  in  ALUOP_W  ALU operation
ex_flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
ex_hold  in  1  downstream (data memory) busy; freeze the pipeline
stall  out  1  freeze PC and IF/ID this cycle (combinational)
ID_EX_valid  out  1  registered valid
ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm  out  XLEN each  registered data
ID_EX_rd_reg1, ID_EX_rd_reg2, ID_EX_wr_reg  out  5 each  registered rs1/rs2/rd indices
ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg, ID_EX_alusrc, ID_EX_branch  out  1 each  registered control
ID_EX_aluop  out  ALUOP_W  registered ALU op

Behaviour:
- Bubble definition: every ID_EX_* output is zero, including ID_EX_valid, the register indices and the data fields.
- Reset: all ID_EX_* outputs load the bubble. stall follows the combinational equation below and is not forced by rst.
- load_use (combinational) = id_valid & ID_EX_valid & ID_EX_memread & (ID_EX_wr_reg != 0) & ((id_uses_rs1 & id_rs1 == ID_EX_wr_reg) | (id_uses_rs2 & id_rs2 == ID_EX_wr_reg)).
- stall = ex_hold | (load_use & !ex_flush).
- Next-state priority, evaluated at each rising edge:
  1. rst: load bubble.
  2. ex_hold: all ID_EX_* keep their values. ex_flush and load_use are ignored; EX re-asserts flush after the hold ends.
  3. ex_flush: load bubble. The ID instruction is discarded, so no stall.
  4. load_use: load bubble. stall=1 for exactly one cycle, because the bubble clears ID_EX_memread.
  5. Otherwise: capture all id_* fields. ID_EX_valid takes id_valid. If id_valid=0, all control fields are zeroed.
- Latency: 1 cycle from ID inputs to ID_EX_* outputs.
- A load writing x0 never stalls.
- A consumer with id_uses_rsN=0 never stalls on that operand. Examples: LUI/JAL do not use rs1; I-type instructions do not use rs2.
- Back-to-back loads with a dependent chain: one bubble per dependent pair.
- Reset asserted mid-stall or mid-hold: bubble next cycle. Hold state is not retained.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds two outputs, each 32 bits and reset to 0:
  - perf_stall_cnt: increments on every cycle with load_use & !ex_flush & !ex_hold & !rst.
  - perf_flush_cnt: increments on every cycle with ex_flush & !ex_hold & !rst.
  - Both counters saturate at 0xFFFFFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Normal capture: id_valid=1, id_pc=0x100, rd=5, regwrite=1, aluop=3, no hazards -> next cycle ID_EX_pc=0x100, ID_EX_wr_reg=5, ID_EX_regwrite=1, ID_EX_aluop=3; stall=0.
- Load-use: LW x5 in ID_EX (memread=1), ID has ADD rs1=5 with id_uses_rs1=1 -> stall=1 that cycle, next ID_EX is bubble. Following cycle stall=0 and ADD is captured.
- No false stall: ID_EX LW x0, consumer rs1=0 -> stall=0. ID_EX LW x5, consumer LUI (id_uses_rs1=0, id_rs1=5) -> stall=0.
- Flush beats load-use: load_use condition true and ex_flush=1 -> stall=0, next ID_EX is bubble.
- Hold: ex_hold=1 for 3 cycles with changing id_* and ex_flush=1 -> stall=1 all 3 cycles, ID_EX_* unchanged throughout. Capture resumes the cycle after hold drops.
- Reset mid-hold: ex_hold=1, rst=1 -> next ID_EX is bubble. With HAZARD_PERF_CNT_EN defined, both counters read 0 after reset and perf_stall_cnt=1 after the load-use case.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold handling.
// Optional saturating stall/flush performance counters under `HAZARD_PERF_CNT_EN.
module id_ex_hazard_stage #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_rs1_data,
   input  logic [XLEN-1:0]    id_rs2_data,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [4:0]         id_rs1,
   input  logic [4:0]         id_rs2,
   input  logic [4:0]         id_rd,
   input  logic               id_uses_rs1,
   input  logic               id_uses_rs2,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_memtoreg,
   input  logic               id_alusrc,
   input  logic               id_branch,
   input  logic [ALUOP_W-1:0] id_aluop,
   input  logic               ex_flush,
   input  logic               ex_hold,
   output logic               stall,
   output logic               ID_EX_valid,
   output logic [XLEN-1:0]    ID_EX_pc,
   output logic [XLEN-1:0]    ID_EX_rs1_data,
   output logic [XLEN-1:0]    ID_EX_rs2_data,
   output logic [XLEN-1:0]    ID_EX_imm,
   output logic [4:0]         ID_EX_rd_reg1,
   output logic [4:0]         ID_EX_rd_reg2,
   output logic [4:0]         ID_EX_wr_reg,
   output logic               ID_EX_regwrite,
   output logic               ID_EX_memread,
   output logic               ID_EX_memwrite,
   output logic               ID_EX_memtoreg,
   output logic               ID_EX_alusrc,
   output logic               ID_EX_branch,
   output logic [ALUOP_W-1:0] ID_EX_aluop
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt
`endif
);

   typedef struct packed {
      logic               valid;
      logic [XLEN-1:0]    pc;
      logic [XLEN-1:0]    rs1_data;
      logic [XLEN-1:0]    rs2_data;
      logic [XLEN-1:0]    imm;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [4:0]         rd;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               memtoreg;
      logic               alusrc;
      logic               branch;
      logic [ALUOP_W-1:0] aluop;
   } stage_t;

   stage_t stage_q, stage_d;
   logic   load_use;

   assign load_use = id_valid & stage_q.valid & stage_q.memread & (stage_q.rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == stage_q.rd)) |
                      (id_uses_rs2 & (id_rs2 == stage_q.rd)));

   // A flush discards the ID instruction, so it also cancels a pending load-use stall.
   assign stall = ex_hold | (load_use & ~ex_flush);

   always_comb begin
      stage_d = stage_q;
      if (!ex_hold) begin
         if (ex_flush || load_use) begin
            stage_d = '0;
         end else begin
            stage_d.valid    = id_valid;
            stage_d.pc       = id_pc;
            stage_d.rs1_data = id_rs1_data;
            stage_d.rs2_data = id_rs2_data;
            stage_d.imm      = id_imm;
            stage_d.rs1      = id_rs1;
            stage_d.rs2      = id_rs2;
            stage_d.rd       = id_rd;
            stage_d.regwrite = id_regwrite & id_valid;
            stage_d.memread  = id_memread  & id_valid;
            stage_d.memwrite = id_memwrite & id_valid;
            stage_d.memtoreg = id_memtoreg & id_valid;
            stage_d.alusrc   = id_alusrc   & id_valid;
            stage_d.branch   = id_branch   & id_valid;
            stage_d.aluop    = id_aluop    & {ALUOP_W{id_valid}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign ID_EX_valid    = stage_q.valid;
   assign ID_EX_pc       = stage_q.pc;
   assign ID_EX_rs1_data = stage_q.rs1_data;
   assign ID_EX_rs2_data = stage_q.rs2_data;
   assign ID_EX_imm      = stage_q.imm;
   assign ID_EX_rd_reg1  = stage_q.rs1;
   assign ID_EX_rd_reg2  = stage_q.rs2;
   assign ID_EX_wr_reg   = stage_q.rd;
   assign ID_EX_regwrite = stage_q.regwrite;
   assign ID_EX_memread  = stage_q.memread;
   assign ID_EX_memwrite = stage_q.memwrite;
   assign ID_EX_memtoreg = stage_q.memtoreg;
   assign ID_EX_alusrc   = stage_q.alusrc;
   assign ID_EX_branch   = stage_q.branch;
   assign ID_EX_aluop    = stage_q.aluop;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!ex_hold) begin
         if (load_use && !ex_flush && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
         if (ex_flush && (flush_cnt_q != '1))              flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed + randomized bench for id_ex_hazard_stage against a cycle-level reference model.
// Define HAZARD_PERF_CNT_EN at compile time to also check the performance counters.
module tb_id_ex_hazard_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, a, b, imm;
      logic [4:0]  r1, r2, wr;
      logic        rw, mr, mw, mtr, as, br;
      logic [3:0]  op;
   } ex_t;

   localparam logic [5:0] CTL_ALU  = 6'b100000;
   localparam logic [5:0] CTL_LOAD = 6'b110110;

   logic        clk = 1'b0;
   logic        rst, id_valid, id_uses_rs1, id_uses_rs2;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch;
   logic [3:0]  id_aluop;
   logic        ex_flush, ex_hold;

   logic        stall, ID_EX_valid;
   logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
   logic [4:0]  ID_EX_rd_reg1, ID_EX_rd_reg2, ID_EX_wr_reg;
   logic        ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg, ID_EX_alusrc, ID_EX_branch;
   logic [3:0]  ID_EX_aluop;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
   logic [31:0] m_stall_cnt, m_flush_cnt;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   ex_t  em, snap;
   ex_t  dut_s;
   logic last_stall;

   always #5 clk = ~clk;

   id_ex_hazard_stage #(.XLEN(32), .ALUOP_W(4)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_branch(id_branch),
      .id_aluop(id_aluop), .ex_flush(ex_flush), .ex_hold(ex_hold), .stall(stall),
      .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data),
      .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
      .ID_EX_rd_reg1(ID_EX_rd_reg1), .ID_EX_rd_reg2(ID_EX_rd_reg2), .ID_EX_wr_reg(ID_EX_wr_reg),
      .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memread(ID_EX_memread),
      .ID_EX_memwrite(ID_EX_memwrite), .ID_EX_memtoreg(ID_EX_memtoreg),
      .ID_EX_alusrc(ID_EX_alusrc), .ID_EX_branch(ID_EX_branch), .ID_EX_aluop(ID_EX_aluop)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   assign dut_s = {ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
                   ID_EX_rd_reg1, ID_EX_rd_reg2, ID_EX_wr_reg,
                   ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_memtoreg,
                   ID_EX_alusrc, ID_EX_branch, ID_EX_aluop};

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] r1, r2, rd,
                        input logic u1, u2, input logic [5:0] ctl, input logic [3:0] op);
      rst = 1'b0; ex_flush = 1'b0; ex_hold = 1'b0;
      id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      id_uses_rs1 = u1; id_uses_rs2 = u2;
      {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch} = ctl;
      id_aluop = op;
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
   endtask

   // One clock: check the combinational stall, advance the model, check the registered state.
   task automatic step(input string tag);
      logic dep, exp_stall;
      ex_t  nx;
      #1;
      dep = id_valid && em.valid && em.mr && (em.wr != 5'd0) &&
            ((id_uses_rs1 && id_rs1 == em.wr) || (id_uses_rs2 && id_rs2 == em.wr));
      exp_stall = ex_hold || (dep && !ex_flush);
      last_stall = stall;
      chk({tag, " stall"}, stall, exp_stall);
      if (rst) nx = '0;
      else if (ex_hold) nx = em;
      else if (ex_flush || dep) nx = '0;
      else begin
         nx.valid = id_valid; nx.pc = id_pc; nx.a = id_rs1_data; nx.b = id_rs2_data;
         nx.imm = id_imm; nx.r1 = id_rs1; nx.r2 = id_rs2; nx.wr = id_rd;
         {nx.rw, nx.mr, nx.mw, nx.mtr, nx.as, nx.br} = id_valid ?
            {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch} : 6'd0;
         nx.op = id_valid ? id_aluop : 4'd0;
      end
`ifdef HAZARD_PERF_CNT_EN
      if (rst) begin
         m_stall_cnt = 0; m_flush_cnt = 0;
      end else if (!ex_hold) begin
         if (dep && !ex_flush && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
         if (ex_flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
      end
`endif
      @(posedge clk);
      em = nx;
      #1;
      chk({tag, " regs"}, dut_s, em);
`ifdef HAZARD_PERF_CNT_EN
      chk({tag, " stall_cnt"}, perf_stall_cnt, m_stall_cnt);
      chk({tag, " flush_cnt"}, perf_flush_cnt, m_flush_cnt);
`endif
      @(negedge clk);
   endtask

   initial begin
      drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0, 4'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      em = '0;
`ifdef HAZARD_PERF_CNT_EN
      m_stall_cnt = 0; m_flush_cnt = 0;
      chk("reset stall_cnt", perf_stall_cnt, 32'd0);
      chk("reset flush_cnt", perf_flush_cnt, 32'd0);
`endif
      chk("reset regs", dut_s, ex_t'('0));
      chk("reset stall", stall, 1'b0);
      @(negedge clk);

      // Normal capture
      drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, CTL_ALU, 4'd3);
      step("cap");
      chk("cap pc", ID_EX_pc, 32'h100);
      chk("cap rd", ID_EX_wr_reg, 5'd5);
      chk("cap regwrite", ID_EX_regwrite, 1'b1);
      chk("cap aluop", ID_EX_aluop, 4'd3);
      chk("cap nostall", last_stall, 1'b0);

      // Load-use: LW x5 then ADD x7, x5, x6
      drive(1'b1, 32'h104, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTL_LOAD, 4'd0);
      step("lw");
      drive(1'b1, 32'h108, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, CTL_ALU, 4'd0);
      step("lu");
      chk("lu stall", last_stall, 1'b1);
      chk("lu bubble", dut_s, ex_t'('0));
      step("lu after");
      chk("lu after stall", last_stall, 1'b0);
      chk("lu after pc", ID_EX_pc, 32'h108);

      // No false stalls
      drive(1'b1, 32'h10c, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, CTL_LOAD, 4'd0);
      step("lw x0");
      drive(1'b1, 32'h110, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, CTL_ALU, 4'd0);
      step("use x0");
      chk("x0 nostall", last_stall, 1'b0);
      drive(1'b1, 32'h114, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTL_LOAD, 4'd0);
      step("lw x5");
      drive(1'b1, 32'h118, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, CTL_ALU, 4'd0);
      step("lui");
      chk("lui nostall", last_stall, 1'b0);

      // Flush beats load-use
      drive(1'b1, 32'h11c, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTL_LOAD, 4'd0);
      step("lw f");
      drive(1'b1, 32'h120, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, CTL_ALU, 4'd0);
      ex_flush = 1'b1;
      step("flush");
      chk("flush nostall", last_stall, 1'b0);
      chk("flush bubble", ID_EX_valid, 1'b0);

      // Hold for three cycles with flush asserted and changing ID inputs
      drive(1'b1, 32'h124, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, CTL_ALU, 4'd6);
      step("pre hold");
      snap = em;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h200 + 32'(i), 5'd4, 5'd4, 5'd1, 1'b1, 1'b1, CTL_LOAD, 4'd2);
         ex_hold = 1'b1; ex_flush = 1'b1;
         step("hold");
         chk("hold stall", last_stall, 1'b1);
         chk("hold frozen", dut_s, snap);
      end
      drive(1'b1, 32'h128, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, CTL_ALU, 4'd1);
      step("post hold");
      chk("post hold pc", ID_EX_pc, 32'h128);

      // Reset during hold
      ex_hold = 1'b1; rst = 1'b1;
      step("rst hold");
      chk("rst hold valid", ID_EX_valid, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
      chk("rst cnt", perf_stall_cnt, 32'd0);
`endif
      drive(1'b1, 32'h12c, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTL_LOAD, 4'd0);
      step("lw p");
      drive(1'b1, 32'h130, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, CTL_ALU, 4'd0);
      step("lu p");
      chk("lu p stall", last_stall, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
      chk("perf after lu", perf_stall_cnt, 32'd1);
`endif

      // Randomized traffic with a small register pool to provoke dependencies
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 6'($urandom), 4'($urandom));
         ex_flush = ($urandom_range(0, 7) == 0);
         ex_hold  = ($urandom_range(0, 7) == 0);
         rst      = ($urandom_range(0, 31) == 0);
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
